// File: rtl/axi_ni_send_payload_serializer.sv
// Packs one write payload (byte enables + data) into the NoC request-payload layout
// and streams it out as body/tail flits, one flit per accepted handshake.
module axi_ni_send_payload_serializer #(
  parameter int FLIT_WIDTH  = 32,
  parameter int FTYPE_WIDTH = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int BE_WIDTH    = DATA_WIDTH/8,
  parameter int ENDIANNESS  = 0,
  parameter logic [FTYPE_WIDTH-1:0] BODY_TYPE = 2'b01,
  parameter logic [FTYPE_WIDTH-1:0] TAIL_TYPE = 2'b10,
  localparam int BASE_WIDTH = FLIT_WIDTH - FTYPE_WIDTH,
  localparam int NFLITS     = (BE_WIDTH + DATA_WIDTH + BASE_WIDTH - 1) / BASE_WIDTH,
  localparam int CNT_W      = (NFLITS > 1) ? $clog2(NFLITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [BE_WIDTH-1:0]   be_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic [CNT_W-1:0]      flit_count,
  output logic                  busy
);

  localparam int P_W   = NFLITS * BASE_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NFLITS - 1);

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  state_t                state, state_nxt;
  logic [P_W-1:0]        p, p_nxt, p_load;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] d_sw;

  // Big-endian mode mirrors bytes so the receive side can undo it symmetrically.
  for (genvar i = 0; i < NB; i++) begin : g_bswap
    assign d_sw[8*i +: 8] = (ENDIANNESS != 0) ? data_in[8*(NB-1-i) +: 8] : data_in[8*i +: 8];
  end

  always_comb begin
    p_load = '0;
    p_load[BE_WIDTH-1:0] = be_in;
    p_load[BE_WIDTH +: DATA_WIDTH] = d_sw;
  end

  function automatic logic [FLIT_WIDTH-1:0] flit_of(input logic [P_W-1:0] pv,
                                                    input logic [CNT_W-1:0] k);
    return {pv[BASE_WIDTH*k +: BASE_WIDTH], (k == LAST) ? TAIL_TYPE : BODY_TYPE};
  endfunction

  assign flit_valid = (state == SEND);
  assign busy       = (state == SEND);
  assign flit_count = cnt;
  assign load_ready = !rst && ((state == IDLE) ||
                               (state == SEND && cnt == LAST && flit_ready));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    p_nxt     = p;
    unique case (state)
      IDLE: begin
        if (load_valid) begin
          state_nxt = SEND;
          cnt_nxt   = '0;
          p_nxt     = p_load;
        end
      end
      SEND: begin
        if (flit_ready) begin
          if (cnt != LAST) begin
            cnt_nxt = cnt + CNT_W'(1);
          end else if (load_valid) begin
            // Tail and next load share a cycle: no bubble between payloads.
            cnt_nxt = '0;
            p_nxt   = p_load;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      p        <= '0;
      cnt      <= '0;
      flit_out <= '0;
    end else begin
      state    <= state_nxt;
      p        <= p_nxt;
      cnt      <= cnt_nxt;
      flit_out <= flit_of(p_nxt, cnt_nxt);
    end
  end

endmodule

// File: doc/axi_ni_send_payload_serializer.md
# axi_ni_send_payload_serializer

Initiator-side NI block that accepts one request payload (write data plus byte enables) per handshake, packs it into a payload register in the NoC request-payload layout, and emits it as a stream of payload flits. Each flit carries a flit-type field in its low bits and payload bits above it. The target NI's receive payload register deserializes this stream, so packing, bit order and byte order must be its exact inverse. The block sits between the NI packet-build FSM, which supplies the header flits and calls this block for the payload phase, and the NI output buffer.

## Interface
- FLIT_WIDTH, 32, flit width in bits
- FTYPE_WIDTH, 2, width of the flit-type field at flit[FTYPE_WIDTH-1:0]
- DATA_WIDTH, 32, write-data width; multiple of 8
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- ENDIANNESS, 0, 0 = little endian, 1 = big endian (byte-swap data before packing)
- BODY_TYPE, 2'b01, flit-type code for non-final payload flits
- TAIL_TYPE, 2'b10, flit-type code for the final payload flit
- Derived: BASE_WIDTH = FLIT_WIDTH-FTYPE_WIDTH; NFLITS = ceil((BE_WIDTH+DATA_WIDTH)/BASE_WIDTH); CNT_W = max(1, clog2(NFLITS))
- Ports:
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- load_valid  in  1  payload available
- load_ready  out  1  block can accept a payload this cycle
- be_in  in  BE_WIDTH  byte enables
- data_in  in  DATA_WIDTH  write data
- flit_out  out  FLIT_WIDTH  current flit
- flit_valid  out  1  flit_out valid
- flit_ready  in  1  downstream accepts flit_out
- flit_count  out  CNT_W  index of the flit on flit_out; 0 for the first payload flit
- busy  out  1  payload loaded and not yet fully sent

## Operation
- Payload register P, NFLITS*BASE_WIDTH bits:
  - P[BE_WIDTH-1:0] = be_in
  - P[BE_WIDTH+DATA_WIDTH-1:BE_WIDTH] = D
  - remaining upper bits = 0
- D = data_in when ENDIANNESS = 0. When ENDIANNESS = 1, byte i of D = byte (DATA_WIDTH/8-1-i) of data_in.
- Flit k = {P[BASE_WIDTH*k+BASE_WIDTH-1 : BASE_WIDTH*k], type}.
  - type = TAIL_TYPE when k = NFLITS-1; otherwise type = BODY_TYPE.
- FSM states:
  - IDLE: flit_valid = 0, load_ready = 1. On load_valid: capture P, flit_count := 0, go to SEND.
  - SEND: flit_valid = 1.
    - On flit_ready with flit_count < NFLITS-1: increment flit_count.
    - On flit_ready with flit_count = NFLITS-1 (tail accepted):
      - if load_valid in the same cycle, capture the new P, set flit_count := 0, and stay in SEND;
      - otherwise go to IDLE.
- load_ready = (state == IDLE) || (state == SEND && flit_count == NFLITS-1 && flit_ready). It is forced to 0 while rst is high.
- flit_out is a registered slice of P selected by flit_count, held stable while flit_valid && !flit_ready.
- busy = (state == SEND).
- data_in and be_in are sampled only on a load handshake; they are don't-care at all other times.

## Timing
- Reset (rst high at a clock edge): state = IDLE, P = 0, flit_out = 0, flit_valid = 0, flit_count = 0, busy = 0. load_ready is 1 from the first cycle after rst deasserts.
- Load-to-first-flit latency: 1 cycle. A load handshake at edge N presents flit 0 valid after edge N.
- Throughput: 1 flit per cycle while flit_ready is held high. Back-to-back payloads leave no bubble between the tail of one payload and flit 0 of the next.
- Stall: while flit_ready = 0, flit_out, flit_count and flit_valid hold their values.
- rst mid-packet: all remaining flits are dropped and the block returns to the reset values above. No partial tail is emitted.
- flit_ready while flit_valid = 0 is ignored.

## Test plan
- ENDIANNESS=0, data_in=0x11223344, be_in=4'hA, flit_ready=1 → flit0 = 0x488CD129 with flit_count 0, then flit1 = 0x00000012 with flit_count 1; then IDLE with busy=0.
- ENDIANNESS=1, same inputs → flit0 = 0x0CC88469, then flit1 = 0x00000046.
- Hold flit_ready=0 for 3 cycles during flit0 → flit0 remains stable with flit_valid=1 and load_ready=0; on release, flit1 appears the next cycle.
- Two payloads with load_valid held and flit_ready=1 → flits P0f0, P0f1, P1f0, P1f1 on consecutive cycles; load_ready pulses in the P0 tail cycle.
- Assert rst while flit0 is valid → the next cycle shows flit_valid=0, flit_count=0, flit_out=0, and load_ready=1 after rst falls.
- Round-trip: feed the emitted flits into the target NI receive payload register, using flit_count as its count input and flit_valid && flit_ready as its sample enable, with 1000 random data/BE values in both endiannesses → recovered data and byte enables equal the inputs.
